reg_file_swap: RTL

//  Parametrised register file for the datapath: DEPTH x DW storage, two combinational read ports
//  and a dedicated reg-0 (accumulator) output. Adds async active-low clear, a write-accept

---
 rtl/reg_file_swap.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reg_file_swap.sv
// -----------------------------------------------------------------------------
// reg_file_swap
//   DEPTH x DW register file (DEPTH = 2**AW) with two combinational read ports,
//   a dedicated reg-0 (accumulator) output, a write-accept handshake, and an
//   atomic two-register swap engine built as a 2-state FSM (IDLE / COMMIT).
//
// Parameters
//   DW  data width in bits
//   AW  address width; DEPTH = 2**AW
//
// Ports
//   clk, rst_n            clock (posedge) / asynchronous active-low clear
//   wr_en, wr_addr,
//   dat_in, wr_ok         write request; wr_ok says the write lands at the
//                         next posedge (combinational accept)
//   rd_addrA, datA_out    read port A (combinational)
//   rd_addrB, datB_out    read port B (combinational)
//   dat0_out              contents of register 0
//   swap_req, swap_a,
//   swap_b                swap request and operand addresses (sampled in IDLE)
//   swap_busy             high while the swap is in COMMIT
//   swap_done             registered one-cycle pulse after the swap commits
//
// Configuration macro
//   BYPASS_EN  when defined, an accepted write is forwarded combinationally to
//              any read output whose address matches wr_addr (port A, port B,
//              reg 0). Swap results are never forwarded.
// -----------------------------------------------------------------------------
module reg_file_swap #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  output logic          wr_ok,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic [DW-1:0] dat0_out,
  input  logic          swap_req,
  input  logic [AW-1:0] swap_a,
  input  logic [AW-1:0] swap_b,
  output logic          swap_busy,
  output logic          swap_done
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] core_q [DEPTH];
  logic [DW-1:0] core_d [DEPTH];
  logic [AW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] ta_q, ta_d, tb_q, tb_d;
  logic          swap_done_q, swap_done_d;
  logic          swap_start;

  // A swap request seen in IDLE starts a swap and wins over a same-cycle write.
  assign swap_start = swap_req && (state_q == IDLE);

  // Writes are refused while a swap is starting or committing, so a write and
  // a swap commit never target the storage in the same cycle.
  assign wr_ok = wr_en && rst_n && !swap_busy && !swap_start;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (swap_req) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    swap_busy = (state_q == COMMIT);
    swap_done = swap_done_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: operand latches, storage, done pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    ta_d        = ta_q;
    tb_d        = tb_q;
    swap_done_d = (state_q == COMMIT);
    core_d      = core_q;

    // Capture addresses and pre-edge operand values when the swap starts.
    if (swap_start) begin
      a_d  = swap_a;
      b_d  = swap_b;
      ta_d = core_q[swap_a];
      tb_d = core_q[swap_b];
    end

    if (wr_ok) begin
      core_d[wr_addr] = dat_in;
    end

    // With a_q == b_q both assignments hit one register with the same value,
    // so a self-swap leaves the contents unchanged.
    if (state_q == COMMIT) begin
      core_d[a_q] = tb_q;
      core_d[b_q] = ta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      ta_q        <= '0;
      tb_q        <= '0;
      swap_done_q <= 1'b0;
      // NOTE: the storage is built from flops (not a RAM macro) precisely so
      // the asynchronous clear can zero every register at once.
      for (int i = 0; i < DEPTH; i++) begin
        core_q[i] <= '0;
      end
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      ta_q        <= ta_d;
      tb_q        <= tb_d;
      swap_done_q <= swap_done_d;
      for (int i = 0; i < DEPTH; i++) begin
        core_q[i] <= core_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
`ifdef BYPASS_EN
  // Write-through forwarding: an accepted write is visible in the same cycle.
  always_comb begin
    datA_out = core_q[rd_addrA];
    datB_out = core_q[rd_addrB];
    dat0_out = core_q[0];
    if (wr_ok && (wr_addr == rd_addrA)) datA_out = dat_in;
    if (wr_ok && (wr_addr == rd_addrB)) datB_out = dat_in;
    if (wr_ok && (wr_addr == '0))       dat0_out = dat_in;
  end
`else
  // Stored contents only; new data appears after the write edge.
  always_comb begin
    datA_out = core_q[rd_addrA];
    datB_out = core_q[rd_addrB];
    dat0_out = core_q[0];
  end
`endif

endmodule
